viterbi_acs_pmu: RTL and testbench

- Parametrised successor to the fixed 4-state serial path-metric unit in the Viterbi decoder datapath.
- Accepts one symbol of pre-computed branch metrics per handshake and runs serial add-compare-select (ACS) over 2^(K-1) states, one state per cycle.
- Holds register-exchange survivors of configurable depth and emits one decoded bit per symbol once the survivors are full.
- Adds valid/ready handshakes, frame restart, saturating metrics and overflow reporting.

---
 rtl/viterbi_acs_pmu.sv | 232 +++++++++++++++++++++++
 tb/tb_viterbi_acs_pmu.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_acs_pmu.sv
// viterbi_acs_pmu: serial add-compare-select path-metric unit with
// register-exchange survivors for a rate-1/2 convolutional code of
// constraint length K. One symbol of branch metrics is accepted per
// handshake. The ACS runs over the 2^(K-1) states one state per cycle, and
// one decoded bit is emitted per symbol once the survivors hold DEPTH bits.
// Optional build macro: VITERBI_METRIC_NORM_EN subtracts the best metric
// from all committed metrics once the best metric reaches half range.
// K must be at least 3. MW must be at least BMW.
module viterbi_acs_pmu #(
    parameter int             K         = 3,
    parameter logic [K-1:0]   G0        = 3'o7,
    parameter logic [K-1:0]   G1        = 3'o5,
    parameter int             MW        = 6,
    parameter int             BMW       = 3,
    parameter int             DEPTH     = 16,
    parameter int             INIT_BIAS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sof,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4*BMW-1:0] bm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [MW-1:0]    out_metric,
    output logic             ovf
);

    localparam int M      = K - 1;
    localparam int NSTATE = 1 << M;
    localparam int FW     = $clog2(DEPTH + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACS    = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam logic [1:0] OUT    = 2'd3;

    localparam logic [MW-1:0] MAX_METRIC = '1;
    localparam logic [MW-1:0] BIAS       = MW'(INIT_BIAS);
    localparam logic [FW-1:0] FILL_FULL  = FW'(DEPTH);
    localparam logic [M-1:0]  LAST_IDX   = M'(NSTATE - 1);

    typedef logic [NSTATE-1:0][MW-1:0]    metricVec_t;
    typedef logic [NSTATE-1:0][DEPTH-1:0] survVec_t;

    // State zero starts at metric 0; every other state starts biased so the
    // decoder assumes the encoder begins a frame in the all-zero state.
    function automatic metricVec_t initMetrics();
        metricVec_t v;
        for (int s = 0; s < NSTATE; s++) begin
            v[s] = (s == 0) ? '0 : BIAS;
        end
        return v;
    endfunction

    // Codeword index {c0,c1} produced when input bit b leaves state s.
    function automatic logic [1:0] codeWord(input logic b, input logic [M-1:0] s);
        logic [K-1:0] r;
        r = {b, s};
        return {^(G0 & r), ^(G1 & r)};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [M-1:0]     idx_q, idx_d;
    logic [4*BMW-1:0] bm_q;
    metricVec_t       metric_q;
    survVec_t         surv_q;
    metricVec_t       newMetric_q;
    survVec_t         newSurv_q;
    logic [M-1:0]     bestIdx_q;
    logic [MW-1:0]    bestVal_q;
    logic [FW-1:0]    fill_q;
    logic             ovf_q;
    logic             outBit_q;
    logic [MW-1:0]    outMetric_q;

    logic             accept;
    logic [FW-1:0]    fillInc;
    logic [BMW-1:0]   bmArr [4];
    logic             decBit;
    logic [M-1:0]     pred0, pred1, predSel;
    logic [MW:0]      sum0, sum1;
    logic             clip0, clip1, pick1;
    logic [MW-1:0]    cand0, cand1, selMetric;
    logic [DEPTH-1:0] selSurv;
    logic [MW-1:0]    normSub;

    assign accept    = (state_q == IDLE) && in_valid;
    assign fillInc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_bit   = outBit_q;
    assign out_metric = outMetric_q;
    assign ovf       = ovf_q;

`ifdef VITERBI_METRIC_NORM_EN
    // Rebase all metrics on the best one once it reaches the upper half of
    // the metric range, keeping the spread representable.
    assign normSub = bestVal_q[MW-1] ? bestVal_q : '0;
`else
    assign normSub = '0;
`endif

    // One butterfly half per cycle: both candidates into target state idx,
    // with saturation, the tie going to the even predecessor.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bmArr[i] = bm_q[BMW*i +: BMW];
        end
        decBit  = idx_q[M-1];
        pred0   = {idx_q[M-2:0], 1'b0};
        pred1   = {idx_q[M-2:0], 1'b1};
        sum0    = {1'b0, metric_q[pred0]} + (MW+1)'(bmArr[codeWord(decBit, pred0)]);
        sum1    = {1'b0, metric_q[pred1]} + (MW+1)'(bmArr[codeWord(decBit, pred1)]);
        clip0   = sum0[MW];
        clip1   = sum1[MW];
        cand0   = clip0 ? MAX_METRIC : sum0[MW-1:0];
        cand1   = clip1 ? MAX_METRIC : sum1[MW-1:0];
        pick1   = (cand1 < cand0);
        predSel = pick1 ? pred1 : pred0;
        selMetric = pick1 ? cand1 : cand0;
        selSurv = {surv_q[predSel][DEPTH-2:0], decBit};
    end

    // Sequencing: wait for a symbol, sweep all states, commit, then offer
    // the decoded bit only once the survivors are full.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ACS;
                    idx_d   = '0;
                end
            end
            ACS: begin
                idx_d = idx_q + M'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = (fillInc == FILL_FULL) ? OUT : IDLE;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers and the latched branch metrics of the current symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bm_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                bm_q <= bm;
            end
        end
    end

    // Committed trellis state: restarted by sof, updated only in COMMIT so a
    // reset or restart mid-sweep never leaves partial results behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            metric_q <= initMetrics();
            surv_q   <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept && sof) begin
                metric_q <= initMetrics();
                surv_q   <= '0;
                fill_q   <= '0;
                ovf_q    <= 1'b0;
            end else if (state_q == ACS) begin
                if (clip0 || clip1) begin
                    ovf_q <= 1'b1;
                end
            end else if (state_q == COMMIT) begin
                for (int s = 0; s < NSTATE; s++) begin
                    metric_q[s] <= newMetric_q[s] - normSub;
                end
                surv_q <= newSurv_q;
                fill_q <= fillInc;
            end
        end
    end

    // Scratch results of the sweep plus the running best, where only a
    // strictly smaller metric displaces the lower-indexed state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            newMetric_q <= '0;
            newSurv_q   <= '0;
            bestIdx_q   <= '0;
            bestVal_q   <= '0;
        end else if (state_q == ACS) begin
            newMetric_q[idx_q] <= selMetric;
            newSurv_q[idx_q]   <= selSurv;
            if ((idx_q == '0) || (selMetric < bestVal_q)) begin
                bestIdx_q <= idx_q;
                bestVal_q <= selMetric;
            end
        end
    end

    // Output registers are written once per symbol and then held, so they
    // stay stable for as long as the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outBit_q    <= 1'b0;
            outMetric_q <= '0;
        end else if (state_q == COMMIT) begin
            outBit_q    <= newSurv_q[bestIdx_q][DEPTH-1];
            outMetric_q <= bestVal_q - normSub;
        end
    end

endmodule

// File: tb/tb_viterbi_acs_pmu.sv
// tb_viterbi_acs_pmu: scoreboard bench for viterbi_acs_pmu (K=3, 7/5,
// MW=6, BMW=3, DEPTH=16). A behavioural trellis model pushes the expected
// decoded bit and metric whenever a symbol is driven. Each emitted bit is
// popped and compared. Scenario tasks add the known-answer checks.
module tb_viterbi_acs_pmu;

    localparam int MW    = 6;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sof = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [11:0] bm = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_bit;
    logic [MW-1:0] out_metric;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    viterbi_acs_pmu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sof        (sof),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bm         (bm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_metric (out_metric),
        .ovf        (ovf)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic b;
        int   metric;
    } expOut_t;

    expOut_t     expQ[$];
    int          mMetric[4];
    logic [15:0] mSurv[4];
    int          mFill;
    logic        mOvf;
    int          mOutMetric;

    logic        sawOut;
    logic        lastBit;
    logic [MW-1:0] lastMetric;

    int          symNo;
    logic [1:0]  encState;
    logic        frameBits[$];
    int          frameOut;
    logic        pattern[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Encoder for generators 7 and 5: c0 = b^s1^s0, c1 = b^s0.
    function automatic logic [1:0] encode(input logic b, input logic [1:0] s);
        return {b ^ s[1] ^ s[0], b ^ s[0]};
    endfunction

    function automatic int bmOf(input logic [11:0] v, input logic [1:0] cw);
        logic [11:0] sh;
        sh = v >> (3 * cw);
        return int'(sh[2:0]);
    endfunction

    function automatic int hamm(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return int'(x[0]) + int'(x[1]);
    endfunction

    task automatic modelInit();
        for (int s = 0; s < 4; s++) begin
            mMetric[s] = (s == 0) ? 0 : 8;
            mSurv[s] = '0;
        end
        mFill = 0;
        mOvf = 1'b0;
    endtask

    // Full-trellis reference step for one symbol.
    task automatic modelStep(input logic [11:0] bv, input logic s);
        int nm[4];
        logic [15:0] ns[4];
        int bestV, bestI, c0, c1, sub;
        logic [1:0] t2, p0, p1, ps;
        logic b;
        if (s) modelInit();
        bestV = 0;
        bestI = 0;
        for (int t = 0; t < 4; t++) begin
            t2 = 2'(t);
            b = t2[1];
            p0 = {t2[0], 1'b0};
            p1 = {t2[0], 1'b1};
            c0 = mMetric[p0] + bmOf(bv, encode(b, p0));
            c1 = mMetric[p1] + bmOf(bv, encode(b, p1));
            if (c0 > 63) begin c0 = 63; mOvf = 1'b1; end
            if (c1 > 63) begin c1 = 63; mOvf = 1'b1; end
            ps = (c1 < c0) ? p1 : p0;
            nm[t] = (c1 < c0) ? c1 : c0;
            ns[t] = {mSurv[ps][14:0], b};
            if (t == 0 || nm[t] < bestV) begin
                bestV = nm[t];
                bestI = t;
            end
        end
        sub = 0;
`ifdef VITERBI_METRIC_NORM_EN
        if (bestV >= 32) sub = bestV;
`endif
        for (int t = 0; t < 4; t++) begin
            mMetric[t] = nm[t] - sub;
            mSurv[t] = ns[t];
        end
        mOutMetric = bestV - sub;
        if (mFill < DEPTH) mFill++;
        if (mFill == DEPTH) expQ.push_back('{b: ns[bestI][15], metric: mOutMetric});
    endtask

    // Drive one symbol, follow it through the DUT, consume any output.
    task automatic applyStimulus(input logic [11:0] bv, input logic s, input int hold);
        int n;
        logic heldBit;
        logic [MW-1:0] heldMetric;
        expOut_t e;
        logic done;
        sawOut = 1'b0;
        done = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        out_ready = (hold == 0);
        bm = bv;
        sof = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sof = 1'b0;
        modelStep(bv, s);
        n = 0;
        while (!done && n < 16) begin
            if (out_valid === 1'b1) begin
                sawOut = 1'b1;
                heldBit = out_bit;
                heldMetric = out_metric;
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (out_valid !== 1'b1 || out_bit !== heldBit || out_metric !== heldMetric || in_ready !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL backpressure: valid=%b bit=%b metric=%0d ready=%b required 1 %b %0d 0",
                                 out_valid, out_bit, out_metric, in_ready, heldBit, heldMetric);
                    end
                end
                out_ready = 1'b1;
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_output: bit=%b metric=%0d required no output", out_bit, out_metric);
                end else begin
                    e = expQ.pop_front();
                    if (out_bit !== e.b || out_metric !== MW'(e.metric)) begin
                        errors++;
                        $display("[TB] FAIL scoreboard: bit=%b metric=%0d required bit=%b metric=%0d",
                                 out_bit, out_metric, e.b, e.metric);
                    end
                end
                lastBit = out_bit;
                lastMetric = out_metric;
                @(posedge clk); #1;
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL handshake: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
                end
                done = 1'b1;
            end else if (in_ready === 1'b1) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL symbol_timeout: in_ready=%b required 1 within 16 cycles", in_ready);
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_output: pending=%0d required 0", expQ.size());
        end
        expQ.delete();
        checks++;
        if (out_metric !== MW'(mOutMetric)) begin
            errors++;
            $display("[TB] FAIL out_metric: got %0d required %0d", out_metric, mOutMetric);
        end
        checks++;
        if (ovf !== mOvf) begin
            errors++;
            $display("[TB] FAIL ovf: got %b required %b", ovf, mOvf);
        end
        out_ready = 1'b1;
    endtask

    // Next symbol of the 10110010 stream, encoded 7/5, c0 flipped at symbol 5,
    // Hamming metrics; checks decoded bits against the transmitted ones.
    task automatic streamSymbol(input logic s, input int hold);
        logic b;
        logic [1:0] cw, rx;
        logic [11:0] v;
        b = pattern[symNo % 8];
        symNo++;
        if (s) begin
            encState = 2'b00;
            frameBits.delete();
            frameOut = 0;
        end
        cw = encode(b, encState);
        encState = {b, encState[1]};
        rx = (symNo == 5) ? (cw ^ 2'b10) : cw;
        for (int i = 0; i < 4; i++) v[3*i +: 3] = 3'(hamm(2'(i), rx));
        frameBits.push_back(b);
        applyStimulus(v, s, hold);
        if (sawOut) begin
            checks++;
            if (lastBit !== frameBits[frameOut]) begin
                errors++;
                $display("[TB] FAIL decoded_bit: symbol %0d got %b required %b", symNo, lastBit, frameBits[frameOut]);
            end
            frameOut++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bit !== 1'b0 || out_metric !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: ready=%b valid=%b bit=%b metric=%0d ovf=%b required 1 0 0 0 0",
                     in_ready, out_valid, out_bit, out_metric, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset: ready=%b valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_all_zero();
        for (int k = 1; k <= 20; k++) begin
            applyStimulus({3'd2, 3'd1, 3'd1, 3'd0}, k == 1, 0);
            checks++;
            if (sawOut !== (k >= 16)) begin
                errors++;
                $display("[TB] FAIL zero_valid: symbol %0d out=%b required %b", k, sawOut, k >= 16);
            end
            if (k >= 16) begin
                checks++;
                if (lastBit !== 1'b0 || lastMetric !== '0 || ovf !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL zero_output: bit=%b metric=%0d ovf=%b required 0 0 0", lastBit, lastMetric, ovf);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(12'hFFF, k == 1, 0);
`ifdef VITERBI_METRIC_NORM_EN
            checks++;
            if (out_metric >= MW'(39) || ovf !== 1'b0) begin
                errors++;
                $display("[TB] FAIL norm_bound: metric=%0d ovf=%b required <39 and 0", out_metric, ovf);
            end
`endif
        end
`ifndef VITERBI_METRIC_NORM_EN
        checks++;
        if (out_metric !== MW'(63) || ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL saturate: metric=%0d ovf=%b required 63 1", out_metric, ovf);
        end
`endif
    endtask

    task automatic test_error_stream();
        symNo = 0;
        for (int k = 1; k <= 19; k++) begin
            streamSymbol(k == 1, 0);
            if (k == 1) begin
                checks++;
                if (ovf !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL sof_ovf_clear: ovf=%b required 0", ovf);
                end
            end
            if (k < 16) begin
                checks++;
                if (sawOut !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL early_output: symbol %0d out=%b required 0", k, sawOut);
                end
            end
            if (k >= 12) begin
                checks++;
                if (out_metric !== MW'(1)) begin
                    errors++;
                    $display("[TB] FAIL error_metric: symbol %0d got %0d required 1", k, out_metric);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        streamSymbol(1'b0, 10);
        checks++;
        if (sawOut !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_output: out=%b required 1", sawOut);
        end
    endtask

    task automatic test_sof_restart();
        for (int k = 21; k <= 46; k++) begin
            streamSymbol(k == 30, 0);
            checks++;
            if (sawOut !== (k < 30 || k >= 45)) begin
                errors++;
                $display("[TB] FAIL restart_valid: symbol %0d out=%b required %b", k, sawOut, (k < 30 || k >= 45));
            end
            if (k < 30) begin
                checks++;
                if (out_metric !== MW'(1)) begin
                    errors++;
                    $display("[TB] FAIL tail_metric: symbol %0d got %0d required 1", k, out_metric);
                end
            end
            if (k >= 30) begin
                checks++;
                if (ovf !== 1'b0 || out_metric !== '0) begin
                    errors++;
                    $display("[TB] FAIL restart_state: symbol %0d ovf=%b metric=%0d required 0 0", k, ovf, out_metric);
                end
            end
        end
    endtask

    task automatic test_reset_mid_acs();
        bm = 12'hFFF;
        sof = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bit !== 1'b0 || out_metric !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: ready=%b valid=%b bit=%b metric=%0d ovf=%b required 1 0 0 0 0",
                     in_ready, out_valid, out_bit, out_metric, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        modelInit();
        expQ.delete();
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_ready: in_ready=%b required 1", in_ready);
        end
        applyStimulus({3'd1, 3'd4, 3'd3, 3'd2}, 1'b0, 0);
        checks++;
        if (out_metric !== MW'(1) || sawOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_symbol: metric=%0d out=%b required 1 0", out_metric, sawOut);
        end
    endtask

    initial begin
        modelInit();
        test_reset();
        test_all_zero();
        test_saturation();
        test_error_stream();
        test_backpressure();
        test_sof_restart();
        test_reset_mid_acs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
